// File: rtl/file_ram.sv
// PIC16-style file register: general-purpose bytes plus STATUS/FSR, with INDF indirection.
// Combinational read of mem[ea]; write-back and flag updates land on clk when wr_phase is high.
module file_ram #(
  parameter int               ADDR_W     = 7,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] STATUS_RST = 8'h18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_phase,
  input  logic [ADDR_W-1:0] address,
  input  logic              d,
  input  logic              writeEn,
  input  logic [WIDTH-1:0]  ans,
  input  logic [2:0]        flag_we,
  input  logic              z_in,
  input  logic              dc_in,
  input  logic              c_in,
  output logic [WIDTH-1:0]  f,
  output logic [WIDTH-1:0]  status,
  output logic              carry,
  output logic [WIDTH-1:0]  fsr
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] A_INDF   = '0;
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_FSR    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_UNIMP  = ADDR_W'(7);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  status_q, status_d;
  logic [WIDTH-1:0]  fsr_q, fsr_d;
  logic [ADDR_W-1:0] ea;
  logic              file_we;
  logic              mem_we;
  logic [2:0]        flag_in;

  // Single level of indirection; FSR upper bits fall off so ea wraps.
  assign ea      = (address == A_INDF) ? fsr_q[ADDR_W-1:0] : address;
  assign file_we = wr_phase & writeEn & d;
  assign mem_we  = file_we && (ea != A_INDF) && (ea != A_STATUS)
                           && (ea != A_FSR)  && (ea != A_UNIMP);
  assign flag_in = {z_in, dc_in, c_in};

  always_comb begin
    f = '0;
    case (ea)
      A_INDF, A_UNIMP: f = '0;
      A_STATUS:        f = status_q;
      A_FSR:           f = fsr_q;
      default:         f = mem_q[ea];
    endcase
  end

  always_comb begin
    status_d = status_q;
    fsr_d    = fsr_q;
    if (file_we && (ea == A_STATUS)) begin
      status_d      = ans;
      // TO/PD are only ever changed by reset.
      status_d[4:3] = status_q[4:3];
    end
    if (file_we && (ea == A_FSR)) begin
      fsr_d = ans;
    end
    if (wr_phase) begin
      for (int i = 0; i < 3; i++) begin
        if (flag_we[i]) status_d[i] = flag_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q <= STATUS_RST;
      fsr_q    <= '0;
    end else begin
      status_q <= status_d;
      fsr_q    <= fsr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem_q[gi] <= '0;
        end else if (mem_we && (ea == ADDR_W'(gi))) begin
          mem_q[gi] <= ans;
        end
      end
    end
  endgenerate

  assign status = status_q;
  assign carry  = status_q[0];
  assign fsr    = fsr_q;

endmodule

// File: tb/tb_file_ram.sv
// Self-checking bench for file_ram: directed scenarios plus randomized traffic
// checked against an array-based model of the file register.
module tb_file_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_phase;
  logic [6:0] address;
  logic       d;
  logic       writeEn;
  logic [7:0] ans;
  logic [2:0] flag_we;
  logic       z_in, dc_in, c_in;
  logic [7:0] f;
  logic [7:0] status;
  logic       carry;
  logic [7:0] fsr;

  int checks   = 0;
  int failures = 0;

  file_ram #(.ADDR_W(7), .WIDTH(8), .STATUS_RST(8'h18)) dut (
    .clk(clk), .reset(reset), .wr_phase(wr_phase), .address(address), .d(d),
    .writeEn(writeEn), .ans(ans), .flag_we(flag_we), .z_in(z_in), .dc_in(dc_in),
    .c_in(c_in), .f(f), .status(status), .carry(carry), .fsr(fsr)
  );

  always #5 clk = ~clk;

  // Reference model of the file register contents.
  logic [7:0] m_mem [128];
  logic [7:0] m_status;
  logic [7:0] m_fsr;

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
    m_status = 8'h18;
    m_fsr    = 8'h00;
  endtask

  function automatic int m_ea(input int a);
    return (a == 0) ? int'(m_fsr) % 128 : a;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    int e;
    e = m_ea(a);
    if (e == 0 || e == 7) return 8'h00;
    if (e == 3) return m_status;
    if (e == 4) return m_fsr;
    return m_mem[e];
  endfunction

  // One transaction: drive at negedge, sample the pre-edge read, update model at posedge.
  task automatic apply(input int a, input bit dd, input bit we, input bit wp,
                       input logic [7:0] an, input logic [2:0] fw, input logic [2:0] fl,
                       output logic [7:0] pre_f);
    int e;
    logic [7:0] new_st;
    @(negedge clk);
    address = a[6:0]; d = dd; writeEn = we; wr_phase = wp; ans = an;
    flag_we = fw; {z_in, dc_in, c_in} = fl;
    #1 pre_f = f;
    @(posedge clk);
    e = m_ea(a);
    new_st = m_status;
    if (wp && we && dd) begin
      if (e == 3) new_st = {an[7:5], m_status[4:3], an[2:0]};
      else if (e == 4) m_fsr = an;
      else if (e != 0 && e != 7) m_mem[e] = an;
    end
    if (wp) for (int i = 0; i < 3; i++) if (fw[i]) new_st[i] = fl[i];
    m_status = new_st;
    #1;
    wr_phase = 1'b0; writeEn = 1'b0; d = 1'b0; flag_we = 3'b000;
  endtask

  task automatic read_f(input int a, output logic [7:0] v);
    @(negedge clk);
    address = a[6:0];
    #1 v = f;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b0; wr_phase = 1'b0; address = 7'h03; d = 1'b0; writeEn = 1'b0;
    ans = 8'h00; flag_we = 3'b000; z_in = 1'b0; dc_in = 1'b0; c_in = 1'b0;
    m_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (status !== 8'h18) begin failures++; $display("FAIL reset_status got=%h exp=18", status); end
    checks++; if (fsr !== 8'h00) begin failures++; $display("FAIL reset_fsr got=%h exp=00", fsr); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
    checks++; if (f !== 8'h18) begin failures++; $display("FAIL reset_f_status got=%h exp=18", f); end
    @(negedge clk) reset = 1'b1;
    read_f(32, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_f_gpr got=%h exp=00", v); end
    $display("test_reset done");
  endtask

  task automatic test_write();
    logic [7:0] pre, v;
    apply(32, 1, 1, 1, 8'h3C, 3'b000, 3'b000, pre);
    checks++; if (pre !== 8'h00) begin failures++; $display("FAIL write_pre_read got=%h exp=00", pre); end
    read_f(32, v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL write_readback got=%h exp=3c", v); end
    checks++; if (status !== 8'h18 || fsr !== 8'h00) begin failures++; $display("FAIL write_side got status=%h fsr=%h exp 18/00", status, fsr); end
    $display("test_write addr=20 data=3c read=%h", v);
  endtask

  task automatic test_gating();
    logic [7:0] pre, v;
    apply(32, 0, 1, 1, 8'h55, 3'b000, 3'b000, pre);
    read_f(32, v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL gate_d got=%h exp=3c", v); end
    apply(32, 1, 0, 1, 8'h66, 3'b000, 3'b000, pre);
    read_f(32, v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL gate_we got=%h exp=3c", v); end
    apply(32, 1, 1, 0, 8'h77, 3'b111, 3'b111, pre);
    read_f(32, v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL gate_phase got=%h exp=3c", v); end
    checks++; if (status !== 8'h18) begin failures++; $display("FAIL gate_phase_status got=%h exp=18", status); end
    $display("test_gating done");
  endtask

  task automatic test_indirect();
    logic [7:0] pre, v;
    apply(4, 1, 1, 1, 8'h25, 3'b000, 3'b000, pre);
    checks++; if (fsr !== 8'h25) begin failures++; $display("FAIL ind_fsr got=%h exp=25", fsr); end
    apply(0, 1, 1, 1, 8'h77, 3'b000, 3'b000, pre);
    read_f(37, v);
    checks++; if (v !== 8'h77) begin failures++; $display("FAIL ind_target got=%h exp=77", v); end
    read_f(0, v);
    checks++; if (v !== 8'h77) begin failures++; $display("FAIL ind_read got=%h exp=77", v); end
    apply(4, 1, 1, 1, 8'hA5, 3'b000, 3'b000, pre);
    read_f(0, v);
    checks++; if (v !== 8'h77) begin failures++; $display("FAIL ind_wrap got=%h exp=77", v); end
    apply(4, 1, 1, 1, 8'h00, 3'b000, 3'b000, pre);
    read_f(0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL ind_indf_read got=%h exp=00", v); end
    apply(0, 1, 1, 1, 8'h11, 3'b000, 3'b000, pre);
    read_f(0, v);
    checks++; if (v !== 8'h00 || fsr !== 8'h00 || status !== 8'h18) begin failures++; $display("FAIL ind_indf_write got f=%h fsr=%h status=%h exp 00/00/18", v, fsr, status); end
    apply(7, 1, 1, 1, 8'hEE, 3'b000, 3'b000, pre);
    read_f(7, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL ind_unimp got=%h exp=00", v); end
    $display("test_indirect done");
  endtask

  task automatic test_status_merge();
    logic [7:0] pre;
    apply(3, 1, 1, 1, 8'hFF, 3'b101, 3'b000, pre);
    checks++; if (status !== 8'hFA) begin failures++; $display("FAIL merge_status got=%h exp=fa", status); end
    checks++; if (carry !== 1'b0) begin failures++; $display("FAIL merge_carry got=%b exp=0", carry); end
    apply(3, 1, 1, 1, 8'h00, 3'b000, 3'b000, pre);
    checks++; if (status !== 8'h18) begin failures++; $display("FAIL merge_topd_kept got=%h exp=18", status); end
    $display("test_status_merge status=%h", status);
  endtask

  task automatic test_flag_only();
    logic [7:0] pre;
    apply(32, 1, 0, 1, 8'h00, 3'b001, 3'b001, pre);
    checks++; if (carry !== 1'b1) begin failures++; $display("FAIL flag_carry got=%b exp=1", carry); end
    checks++; if (status !== 8'h19) begin failures++; $display("FAIL flag_status got=%h exp=19", status); end
    $display("test_flag_only status=%h", status);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pre, v, exp_pre;
    int a;
    for (int n = 0; n < 300; n++) begin
      a = (n % 5 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 127));
      exp_pre = m_read(a);
      apply(a, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 3'($urandom), pre);
      checks++; if (pre !== exp_pre) begin failures++; $display("FAIL rnd_pre_read n=%0d addr=%0d got=%h exp=%h", n, a, pre, exp_pre); end
      checks++; if (status !== m_status || fsr !== m_fsr || carry !== m_status[0]) begin
        failures++; $display("FAIL rnd_regs n=%0d got status=%h fsr=%h carry=%b exp %h/%h", n, status, fsr, carry, m_status, m_fsr);
      end
      a = int'($urandom_range(0, 127));
      read_f(a, v);
      checks++; if (v !== m_read(a)) begin failures++; $display("FAIL rnd_read n=%0d addr=%0d got=%h exp=%h", n, a, v, m_read(a)); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset();
    logic [7:0] pre, v;
    apply(32, 1, 1, 1, 8'h5A, 3'b000, 3'b000, pre);
    apply(4, 1, 1, 1, 8'h40, 3'b000, 3'b000, pre);
    @(negedge clk);
    address = 7'd32; d = 1'b1; writeEn = 1'b1; wr_phase = 1'b1; ans = 8'h99; flag_we = 3'b111;
    {z_in, dc_in, c_in} = 3'b111;
    #2 reset = 1'b0;
    #1;
    m_reset();
    checks++; if (status !== 8'h18 || fsr !== 8'h00) begin failures++; $display("FAIL async_regs got status=%h fsr=%h exp 18/00", status, fsr); end
    checks++; if (f !== 8'h00) begin failures++; $display("FAIL async_mem got=%h exp=00", f); end
    @(posedge clk);
    #1;
    checks++; if (f !== 8'h00 || status !== 8'h18) begin failures++; $display("FAIL async_held got f=%h status=%h exp 00/18", f, status); end
    @(negedge clk);
    wr_phase = 1'b0; writeEn = 1'b0; d = 1'b0; flag_we = 3'b000;
    reset = 1'b1;
    read_f(32, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL async_lost_write got=%h exp=00", v); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_gating();
    test_indirect();
    test_status_merge();
    test_flag_only();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
